div_unit: RTL and testbench

//   Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.

---
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: {HI=remainder, LO=quotient}.
// Latency: start sampled in cycle N, done in cycle N+WIDTH+1; one quotient bit per cycle.
// Backpressure: result held with done=1 until accept; annul cancels from any state.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic                 accept,
    input  logic                 annul,
    output logic                 done,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Iteration state: dvd shifts dividend bits out of the top while
    // quotient bits enter at the bottom, so it ends holding the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    counter;
    logic             sign_a;
    logic             sign_b;
    logic             sgn;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             neg_q;
    logic             neg_r;
    logic             last_iter;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // exact when read back as a W-bit unsigned magnitude.
    always_comb begin
        abs_a = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        abs_b = (signed_div && opb[WIDTH-1]) ? -opb : opb;
    end

    // One restoring step: W+1-bit trial subtract, borrow decides the quotient bit.
    always_comb begin
        rem_shift = {rem, dvd[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor};
        qbit      = ~rem_diff[WIDTH];
        rem_next  = qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {dvd[WIDTH-2:0], qbit};
        last_iter = (counter == LAST_ITER);
    end

    // Sign correction applied to the final step's magnitudes.
    always_comb begin
        neg_q = sgn & (sign_a ^ sign_b);
        neg_r = sgn & sign_a;
        q_fix = neg_q ? -quo_next : quo_next;
        r_fix = neg_r ? -rem_next : rem_next;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; annul overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)     state_nxt = S_BUSY;
            S_BUSY:  if (last_iter) state_nxt = S_DONE;
            S_DONE:  if (accept)    state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
        if (annul) begin
            state_nxt = S_IDLE;
        end
    end

    // Status outputs decode only the state register, so done has no
    // combinational path from start, accept or annul.
    always_comb begin
        done = (state == S_DONE);
        busy = (state == S_BUSY);
    end

    // Datapath: operand capture, iteration, and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvd     <= '0;
            divisor <= '0;
            rem     <= '0;
            counter <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            sgn     <= 1'b0;
            result  <= '0;
        end else if (annul) begin
            // Result keeps its stale value; done already drops with the state.
            counter <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd     <= abs_a;
                        divisor <= abs_b;
                        rem     <= '0;
                        counter <= '0;
                        sign_a  <= opa[WIDTH-1];
                        sign_b  <= opb[WIDTH-1];
                        sgn     <= signed_div;
                    end
                end
                S_BUSY: begin
                    dvd     <= quo_next;
                    rem     <= rem_next;
                    counter <= last_iter ? '0 : counter + CW'(1);
                    if (last_iter) begin
                        result <= {r_fix, q_fix};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus hold, annul and reset sequences.
// Latency: each vector is checked for done exactly 33 clocks after start.
// Backpressure: accept held low to check that the result is frozen.
module tb_div_unit;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             signed_div;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic             accept;
    logic             annul;
    logic             done;
    logic             busy;
    logic [2*W-1:0]   result;

    int tests;
    int fails;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .accept     (accept),
        .annul      (annul),
        .done       (done),
        .busy       (busy),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start with the given operands and wait (bounded) for done.
    task automatic run_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [2*W-1:0] res, output int lat);
        signed_div = sg;
        opa        = a;
        opb        = b;
        start      = 1'b1;
        lat        = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat <= 100);
        res   = result;
        start = 1'b0;
    endtask

    logic [2*W-1:0] res;
    logic [2*W-1:0] held;
    int             lat;
    int             seen;

    initial begin
        tests = 0;
        fails = 0;
        start = 0; signed_div = 0; opa = '0; opb = '0; accept = 0; annul = 0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        check("reset_done",   {63'd0, done}, 64'd0);
        check("reset_busy",   {63'd0, busy}, 64'd0);
        check("reset_result", result, 64'd0);
        tick();
        resetn = 1'b1;
        tick();

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
        vecs[5]  = '{1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234};
        vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'd1,          32'hFFFFFFFB};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[9]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
        vecs[10] = '{1'b1, 32'd0,          32'hFFFFFFFD,   32'd0,          32'd0};
        vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};

        accept = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_result", i), res, {vecs[i].r, vecs[i].q});
            tick();
            check($sformatf("vec%0d_done_drop", i), {63'd0, done}, 64'd0);
        end

        // Hold: accept low for 5 cycles with start still high; no restart.
        accept = 1'b0;
        run_div(1'b0, 32'd100, 32'd7, held, lat);
        check("hold_latency", 64'(lat), 64'(LAT));
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_done", i),   {63'd0, done}, 64'd1);
            check($sformatf("hold%0d_result", i), result, {32'd2, 32'd14});
        end
        accept = 1'b1;
        start  = 1'b0;
        tick();
        check("accept_done_drop", {63'd0, done}, 64'd0);
        check("accept_busy",      {63'd0, busy}, 64'd0);
        run_div(1'b0, 32'd1000, 32'd10, res, lat);
        check("second_latency", 64'(lat), 64'(LAT));
        check("second_result",  res, {32'd0, 32'd100});
        tick();

        // Annul at iteration 10, then annul coinciding with start in IDLE.
        held       = result;
        signed_div = 1'b0;
        opa        = 32'h0000FFFF;
        opb        = 32'd3;
        start      = 1'b1;
        tick();
        check("annul_busy_before", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 10; i++) tick();
        annul = 1'b1;
        tick();
        check("annul_busy",   {63'd0, busy}, 64'd0);
        check("annul_done",   {63'd0, done}, 64'd0);
        check("annul_result", result, held);
        tick();
        check("annul_start_ignored", {63'd0, busy}, 64'd0);
        annul = 1'b0;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen++;
        end
        check("annul_no_done", 64'(seen), 64'd0);

        // Reset at iteration 20 clears outputs immediately.
        opa   = 32'd100;
        opb   = 32'd7;
        start = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("midreset_busy",   {63'd0, busy}, 64'd0);
        check("midreset_done",   {63'd0, done}, 64'd0);
        check("midreset_result", result, 64'd0);
        start = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
